// File: rtl/muldiv_sched_pkg.sv
// muldiv_sched shared types: operation codes, controller states, divider
// iteration count and small operand helpers.
package muldiv_sched_pkg;

    typedef enum logic [2:0] {
        MUL_LO  = 3'd0,
        MUL_HI  = 3'd1,
        MUL_HIU = 3'd2,
        DIV     = 3'd3,
        DIVU    = 3'd4,
        MOD     = 3'd5,
        MODU    = 3'd6
    } mdu_op_t;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL_WAIT = 2'd1,
        S_DIV_RUN  = 2'd2,
        S_DONE     = 2'd3
    } mdu_state_t;

    localparam int DIV_ITERS = 32;

    function automatic logic op_is_div(mdu_op_t op);
        return (op == DIV) || (op == DIVU) || (op == MOD) || (op == MODU);
    endfunction

    function automatic logic op_is_sdiv(mdu_op_t op);
        return (op == DIV) || (op == MOD);
    endfunction

    function automatic logic op_is_rem(mdu_op_t op);
        return (op == MOD) || (op == MODU);
    endfunction

    // Two's-complement magnitude; 0x80000000 maps to itself as unsigned.
    function automatic logic [31:0] mag32(logic [31:0] x, logic sgn);
        return (sgn && x[31]) ? (32'd0 - x) : x;
    endfunction

endpackage

// File: rtl/muldiv_sched_if.sv
// muldiv_sched bus: execute-stage request/result handshake plus the
// external multiplier handshake. master = EX stage + multiplier side,
// slave = the scheduler.
interface muldiv_sched_if;
    import muldiv_sched_pkg::*;

    logic        flush;
    logic        next_rdy_in;
    logic        req_valid;
    mdu_op_t     req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        eu_stall;
    logic        res_valid;
    logic [31:0] res_data;
    logic        mul_en;
    logic        mul_signed;
    logic        mul_flush;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_out;
    logic        mul_done;

    modport master (
        output flush, next_rdy_in, req_valid, req_op, req_a, req_b, mul_out, mul_done,
        input  eu_stall, res_valid, res_data, mul_en, mul_signed, mul_flush, mul_a, mul_b
    );

    modport slave (
        input  flush, next_rdy_in, req_valid, req_op, req_a, req_b, mul_out, mul_done,
        output eu_stall, res_valid, res_data, mul_en, mul_signed, mul_flush, mul_a, mul_b
    );

endinterface

// File: rtl/muldiv_sched_div_iter.sv
// div_iter: restoring divider on operand magnitudes, one quotient bit per
// cycle, sign fixup folded into the final-iteration result.
// Optional MDU_DIV_FAST_EN: divide-by-zero or |dividend| < |divisor|
// completes in the start cycle without iterating.
module div_iter
    import muldiv_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] rem, quo, dvsr, dvd_raw;
    logic        neg_q, neg_r, dz;
    logic [5:0]  cnt;

    logic [32:0] rem_sh;
    logic        ge;
    logic [31:0] sub, rem_nx, quo_nx, fix_q, fix_r;
    logic        last;
    logic        early;

    // One restoring step plus the signed/zero-divisor result fixup.
    always_comb begin
        rem_sh = {rem, quo[31]};
        ge     = rem_sh >= {1'b0, dvsr};
        sub    = rem_sh[31:0] - dvsr;
        rem_nx = ge ? sub : rem_sh[31:0];
        quo_nx = {quo[30:0], ge};
        fix_q  = dz ? 32'hFFFF_FFFF : (neg_q ? (32'd0 - quo_nx) : quo_nx);
        fix_r  = dz ? dvd_raw       : (neg_r ? (32'd0 - rem_nx) : rem_nx);
    end

    assign last = busy && (cnt == 6'(DIV_ITERS - 1));

`ifdef MDU_DIV_FAST_EN
    // Trivial cases resolve from the live operands in the start cycle.
    assign early     = start && ((divisor == 32'd0) ||
                       (mag32(dividend, is_signed) < mag32(divisor, is_signed)));
    assign done      = early || last;
    assign quotient  = early ? ((divisor == 32'd0) ? 32'hFFFF_FFFF : 32'd0) : fix_q;
    assign remainder = early ? dividend : fix_r;
`else
    assign early     = 1'b0;
    assign done      = last;
    assign quotient  = fix_q;
    assign remainder = fix_r;
`endif

    // Load magnitudes on start, then shift/subtract until the last iteration.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem <= '0; quo <= '0; dvsr <= '0; dvd_raw <= '0;
            neg_q <= 1'b0; neg_r <= 1'b0; dz <= 1'b0;
            cnt <= '0; busy <= 1'b0;
        end else if (abort) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start && !early) begin
            rem     <= '0;
            quo     <= mag32(dividend, is_signed);
            dvsr    <= mag32(divisor, is_signed);
            dvd_raw <= dividend;
            neg_q   <= is_signed && (dividend[31] ^ divisor[31]);
            neg_r   <= is_signed && dividend[31];
            dz      <= (divisor == 32'd0);
            cnt     <= '0;
            busy    <= 1'b1;
        end else if (busy) begin
            rem  <= rem_nx;
            quo  <= quo_nx;
            cnt  <= last ? 6'd0 : cnt + 6'd1;
            busy <= !last;
        end
    end

endmodule

// File: rtl/muldiv_sched.sv
// muldiv_sched: EX-stage mul/div controller. Drives the external multiplier
// handshake, runs div_iter, holds the result until downstream accepts.
// Optional MDU_DIV_FAST_EN enables the divider early-out.
module muldiv_sched
    import muldiv_sched_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           rst,
    muldiv_sched_if.slave  bus
);

    mdu_state_t      state;
    mdu_op_t         op_q;
    logic [XLEN-1:0] a_q, b_q;
    logic            sgn_q, mul_en_q, res_valid_q;
    logic [XLEN-1:0] res_data_q;

    logic            div_start, div_busy, div_done;
    logic [31:0]     div_q, div_r, div_res, mul_res;
    mdu_op_t         op_sel;

    assign div_start = (state == S_IDLE) && bus.req_valid && !bus.flush &&
                       op_is_div(bus.req_op) && !div_busy;

    div_iter u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .abort     (bus.flush),
        .is_signed (op_is_sdiv(bus.req_op)),
        .dividend  (bus.req_a),
        .divisor   (bus.req_b),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    // Early-out completes in IDLE, so the op is still only on the live input.
    assign op_sel  = (state == S_IDLE) ? bus.req_op : op_q;
    assign div_res = op_is_rem(op_sel) ? div_r : div_q;
    assign mul_res = (op_q == MUL_LO) ? bus.mul_out[31:0] : bus.mul_out[63:32];

    assign bus.eu_stall   = bus.req_valid && !bus.flush && (state != S_DONE);
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign bus.mul_en     = mul_en_q && !bus.mul_done;
    assign bus.mul_signed = sgn_q;
    assign bus.mul_flush  = bus.flush;
    assign bus.mul_a      = a_q;
    assign bus.mul_b      = b_q;

    // Controller FSM with registered handshake/result outputs; flush wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            op_q        <= MUL_LO;
            a_q         <= '0;
            b_q         <= '0;
            sgn_q       <= 1'b0;
            mul_en_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else if (bus.flush) begin
            state       <= S_IDLE;
            mul_en_q    <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.req_valid) begin
                    op_q  <= bus.req_op;
                    a_q   <= bus.req_a;
                    b_q   <= bus.req_b;
                    sgn_q <= (bus.req_op == MUL_LO) || (bus.req_op == MUL_HI);
                    if (!op_is_div(bus.req_op)) begin
                        state    <= S_MUL_WAIT;
                        mul_en_q <= 1'b1;
                    end else if (div_done) begin
                        state       <= S_DONE;
                        res_valid_q <= 1'b1;
                        res_data_q  <= div_res;
                    end else begin
                        state <= S_DIV_RUN;
                    end
                end
                S_MUL_WAIT: if (bus.mul_done) begin
                    state       <= S_DONE;
                    mul_en_q    <= 1'b0;
                    res_valid_q <= 1'b1;
                    res_data_q  <= mul_res;
                end
                S_DIV_RUN: if (div_done) begin
                    state       <= S_DONE;
                    res_valid_q <= 1'b1;
                    res_data_q  <= div_res;
                end
                S_DONE: if (bus.next_rdy_in) begin
                    state       <= S_IDLE;
                    res_valid_q <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
